apb4_crc_cfg: RTL

APB4_CRC_CFG -- requirements
Module: apb4_crc_cfg

---
 rtl/apb4_crc_cfg.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/apb4_crc_cfg.sv
`default_nettype none
// ============================================================================
// Module   : apb4_crc_cfg
// Purpose  : APB4-programmable CRC engine (width, polynomial, init, xorout,
//            reflection) processing BPC data bits per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module apb4_crc_cfg #(
  parameter int          CRC_W    = 32,
  parameter int          BPC      = 1,
  parameter logic [31:0] POLY_DEF = 32'h04C1_1DB7,
  parameter logic [31:0] INIT_DEF = 32'hFFFF_FFFF
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr
);

  localparam logic [3:0] c_off_ctrl   = 4'd0;
  localparam logic [3:0] c_off_poly   = 4'd1;
  localparam logic [3:0] c_off_initv  = 4'd2;
  localparam logic [3:0] c_off_xorout = 4'd3;
  localparam logic [3:0] c_off_data   = 4'd4;
  localparam logic [3:0] c_off_result = 4'd5;
  localparam logic [3:0] c_off_stat   = 4'd6;
  localparam int         c_bpc_sh     = (BPC == 1) ? 0 : (BPC == 2) ? 1 : (BPC == 4) ? 2 : 3;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_en, r_refin, r_refout;
  logic [1:0]         r_dsize;
  logic [CRC_W-1:0]   r_poly, r_initv, r_xorout, r_crc;
  logic [31:0]        r_data;
  logic [31:0]        r_sh;
  logic [5:0]         r_cnt;

  logic [3:0]         w_off;
  logic               w_mapped, w_busy, w_stall, w_done, w_wr, w_rd, w_data_go;
  logic [5:0]         w_nbits, w_load;
  logic [31:0]        w_dmask, w_din, w_feed;
  logic [CRC_W-1:0]   w_crc_nxt, w_crc_rev, w_res;
  logic [31:0]        w_sh_tmp;
  logic               w_fb;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_off     = paddr[5:2];
  assign w_mapped  = (w_off <= c_off_stat);
  assign w_busy    = (r_state == S_SHIFT);
  // Only STAT may be observed while the engine is shifting.
  assign w_stall   = psel & w_busy & (w_off != c_off_stat);
  assign w_done    = presetn & psel & penable & ~w_stall;
  assign w_wr      = w_done & pwrite & w_mapped;
  assign w_rd      = w_done & ~pwrite & w_mapped;
  assign w_data_go = w_wr & (w_off == c_off_data) & r_en;

  assign pready    = ~w_stall;
  assign pslverr   = w_done & ~w_mapped;
  assign prdata    = w_rd ? w_rdata : 32'h0;
  assign w_unused  = &{1'b0, paddr[31:6], paddr[1:0]};

  // Data word is left-aligned in r_sh so the engine always consumes bit 31 first.
  always_comb begin
    w_nbits = 6'd32;
    w_dmask = 32'hFFFF_FFFF;
    w_feed  = 32'h0;
    case (r_dsize)
      2'd0:    begin w_nbits = 6'd8;  w_dmask = 32'h0000_00FF; end
      2'd1:    begin w_nbits = 6'd16; w_dmask = 32'h0000_FFFF; end
      default: begin w_nbits = 6'd32; w_dmask = 32'hFFFF_FFFF; end
    endcase
    w_din  = pwdata & w_dmask;
    w_load = (w_nbits >> c_bpc_sh) - 6'd1;
    if (r_refin) begin
      w_feed = {<<{w_din}};
    end else begin
      case (r_dsize)
        2'd0:    w_feed = {w_din[7:0], 24'h0};
        2'd1:    w_feed = {w_din[15:0], 16'h0};
        default: w_feed = w_din;
      endcase
    end
  end

  always_comb begin
    w_crc_nxt = r_crc;
    w_sh_tmp  = r_sh;
    w_fb      = 1'b0;
    for (int i = 0; i < BPC; i++) begin
      w_fb      = w_crc_nxt[CRC_W-1] ^ w_sh_tmp[31];
      w_crc_nxt = {w_crc_nxt[CRC_W-2:0], 1'b0} ^ (w_fb ? r_poly : {CRC_W{1'b0}});
      w_sh_tmp  = {w_sh_tmp[30:0], 1'b0};
    end
  end

  assign w_crc_rev = {<<{r_crc}};
  assign w_res     = (r_refout ? w_crc_rev : r_crc) ^ r_xorout;

  always_comb begin
    w_rdata = 32'h0;
    case (w_off)
      c_off_ctrl:   w_rdata[4:0]       = {r_dsize, r_refout, r_refin, r_en};
      c_off_poly:   w_rdata[CRC_W-1:0] = r_poly;
      c_off_initv:  w_rdata[CRC_W-1:0] = r_initv;
      c_off_xorout: w_rdata[CRC_W-1:0] = r_xorout;
      c_off_data:   w_rdata            = r_data;
      c_off_result: w_rdata[CRC_W-1:0] = w_res;
      c_off_stat:   w_rdata[0]         = w_busy;
      default:      w_rdata            = 32'h0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_data_go) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == 6'd0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_en     <= 1'b0;
      r_refin  <= 1'b0;
      r_refout <= 1'b0;
      r_dsize  <= 2'd0;
      r_poly   <= POLY_DEF[CRC_W-1:0];
      r_initv  <= INIT_DEF[CRC_W-1:0];
      r_xorout <= {CRC_W{1'b0}};
      r_crc    <= INIT_DEF[CRC_W-1:0];
      r_data   <= 32'h0;
      r_sh     <= 32'h0;
      r_cnt    <= 6'd0;
    end else begin
      if (w_wr) begin
        case (w_off)
          c_off_ctrl: begin
            r_en     <= pwdata[0];
            r_refin  <= pwdata[1];
            r_refout <= pwdata[2];
            r_dsize  <= pwdata[4:3];
            if (pwdata[5]) r_crc <= r_initv;
          end
          c_off_poly:   r_poly   <= pwdata[CRC_W-1:0];
          c_off_initv:  r_initv  <= pwdata[CRC_W-1:0];
          c_off_xorout: r_xorout <= pwdata[CRC_W-1:0];
          default: ;
        endcase
      end
      if (w_data_go) begin
        r_data <= w_din;
        r_sh   <= w_feed;
        r_cnt  <= w_load;
      end
      if (r_state == S_SHIFT) begin
        r_crc <= w_crc_nxt;
        r_sh  <= w_sh_tmp;
        r_cnt <= r_cnt - 6'd1;
      end
    end
  end

endmodule
`default_nettype wire
